// File: rtl/exp_base2_pkg.sv
// Shared types and constants for the base-2 exponential unit.
// The coefficient table holds 2^(2^-(k+1)) in Q1.15, rounded to nearest.
package exp_base2_pkg;

    localparam int FRAC_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [15:0] exp2_coef(input logic [3:0] k);
        logic [15:0] c;
        case (k)
            4'd0:    c = 16'd46341;
            4'd1:    c = 16'd38968;
            4'd2:    c = 16'd35734;
            4'd3:    c = 16'd34219;
            4'd4:    c = 16'd33486;
            4'd5:    c = 16'd33125;
            4'd6:    c = 16'd32946;
            4'd7:    c = 16'd32857;
            4'd8:    c = 16'd32812;
            4'd9:    c = 16'd32790;
            4'd10:   c = 16'd32779;
            4'd11:   c = 16'd32774;
            4'd12:   c = 16'd32771;
            4'd13:   c = 16'd32769;
            4'd14:   c = 16'd32769;
            default: c = 16'd32768;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/exp2_mul_q15.sv
// Q1.15 x Q1.15 multiply, truncated back to Q1.15 (product >> 15).
module exp2_mul_q15 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);

    logic [31:0] full;
    logic        unused_bits;

    assign full        = 32'(a) * 32'(b);
    assign p           = full[30:15];
    // The running product stays below 2.0, so bit 31 never carries information.
    assign unused_bits = ^{full[31], full[14:0]};

endmodule

// File: rtl/exp_base2_16bit.sv
// Computes 2^(n+f) in Q16.16 by multiplying in one root-of-two factor per set fraction bit.
// state | meaning
// IDLE  | waiting for start_i (ready)
// ITER  | one fraction bit per cycle, acc scaled by C[k] when the bit is set
// SHIFT | scale acc by 2^n into data_o
// DONE  | done_o pulse; ready, a start here goes straight back to ITER
module exp_base2_16bit
    import exp_base2_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [3:0]  ynguyen_i,
    input  logic [15:0] ythapphan_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] data_o
);

    // Bits are consumed MSB first, so FRAC_W below 16 processes only the top bits.
    localparam logic [3:0] K_LAST = 4'(FRAC_W - 1);

    state_e      state;
    logic [15:0] acc;
    logic [15:0] frac_q;
    logic [15:0] coef;
    logic [15:0] mul_p;
    logic [3:0]  k;
    logic [3:0]  n_q;
    logic [3:0]  bit_idx;
    logic        ready;

    assign ready   = (state == ST_IDLE) || (state == ST_DONE);
    assign busy_o  = (state == ST_ITER) || (state == ST_SHIFT);
    assign done_o  = (state == ST_DONE);
    assign bit_idx = 4'd15 - k;
    assign coef    = exp2_coef(k);

    exp2_mul_q15 u_mul (
        .a (acc),
        .b (coef),
        .p (mul_p)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            acc    <= 16'h8000;
            k      <= 4'd0;
            n_q    <= 4'd0;
            frac_q <= 16'd0;
            data_o <= 32'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i && ready) begin
                        n_q    <= ynguyen_i;
                        frac_q <= ythapphan_i;
                        acc    <= 16'h8000;
                        k      <= 4'd0;
                        state  <= ST_ITER;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_ITER: begin
                    if (frac_q[bit_idx]) begin
                        acc <= mul_p;
                    end
                    k <= k + 4'd1;
                    if (k == K_LAST) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // acc < 2^16 and n <= 15 keep the shifted value inside 32 bits.
                    data_o <= {15'd0, acc, 1'b0} << n_q;
                    state  <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_base2_16bit.sv
// Randomised and directed checks of exp_base2_16bit against a real-arithmetic coefficient model.
module tb_exp_base2_16bit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [3:0]  ynguyen_i;
    logic [15:0] ythapphan_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] data_o;

    int          errs   = 0;
    int          checks = 0;
    int          coef_m [16];
    logic [31:0] last_data;

    exp_base2_16bit dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .ynguyen_i   (ynguyen_i),
        .ythapphan_i (ythapphan_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .data_o      (data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Each set fraction bit multiplies by 2^(weight), truncating to Q1.15 after every step.
    function automatic logic [31:0] ref_exp2(input logic [3:0] n, input logic [15:0] f);
        longint acc_m = 32768;
        for (int i = 0; i < 16; i++) begin
            if (f[15-i]) acc_m = (acc_m * longint'(coef_m[i])) / 32768;
        end
        return 32'((acc_m * 2) << n);
    endfunction

    // Called #1 after a rising edge with the DUT ready; returns after the cycle following done_o.
    task automatic conv(input logic [3:0] n, input logic [15:0] f, input bit disturb,
                        output logic [31:0] res);
        int          cnt;
        logic [31:0] exp_v;
        exp_v       = ref_exp2(n, f);
        ynguyen_i   = n;
        ythapphan_i = f;
        start_i     = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cnt     = 0;
        while (!done_o && cnt < 40) begin
            @(posedge clk_i); #1;
            cnt++;
            if (cnt == 1)  chk("busy_iter", {31'd0, busy_o}, 32'd1);
            if (cnt == 16) chk("data_hold", data_o, last_data);
            if (disturb) begin
                if (cnt == 5 || cnt == 10) begin
                    ynguyen_i   = ~n;
                    ythapphan_i = ~f;
                    start_i     = 1'b1;
                end else begin
                    start_i = 1'b0;
                end
            end
        end
        start_i = 1'b0;
        chk("latency", cnt, 32'd17);
        chk("data", data_o, exp_v);
        chk("busy_done", {31'd0, busy_o}, 32'd0);
        res       = data_o;
        last_data = exp_v;
        @(posedge clk_i); #1;
        chk("done_pulse", {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          cnt;
        bit          bad;

        for (int i = 0; i < 16; i++) begin
            coef_m[i] = $rtoi($pow(2.0, $pow(2.0, -(i + 1.0))) * 32768.0 + 0.5);
        end
        last_data   = 32'd0;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        ynguyen_i   = 4'd0;
        ythapphan_i = 16'd0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_data", data_o, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        conv(4'd3, 16'h0000, 1'b0, res);
        chk("n3_f0", res, 32'h0008_0000);
        conv(4'd0, 16'h8000, 1'b0, res);
        chk("sqrt2", res, 32'h0001_6A0A);
        conv(4'd0, 16'hC000, 1'b0, res);
        chk("pow_0p75", res, 32'h0001_AE8A);
        conv(4'd15, 16'h0000, 1'b0, res);
        chk("n15_f0", res, 32'h8000_0000);
        conv(4'd0, 16'h0000, 1'b0, res);
        chk("n0_f0", res, 32'h0001_0000);

        // Mid-conversion start pulses with other operands must be ignored.
        conv(4'd5, 16'h1234, 1'b1, res);
        conv(4'd11, 16'hFFFF, 1'b1, res);

        // start_i held through DONE launches the next conversion back to back.
        ynguyen_i   = 4'd2;
        ythapphan_i = 16'h5A5A;
        start_i     = 1'b1;
        @(posedge clk_i); #1;
        cnt = 0;
        while (!done_o && cnt < 40) begin
            @(posedge clk_i); #1;
            cnt++;
        end
        chk("hold_lat1", cnt, 32'd17);
        chk("hold_data1", data_o, ref_exp2(4'd2, 16'h5A5A));
        ynguyen_i   = 4'd9;
        ythapphan_i = 16'h0F0F;
        cnt = 0;
        do begin
            @(posedge clk_i); #1;
            cnt++;
        end while (!done_o && cnt < 40);
        chk("hold_lat2", cnt, 32'd18);
        chk("hold_data2", data_o, ref_exp2(4'd9, 16'h0F0F));
        start_i = 1'b0;
        @(posedge clk_i); #1;
        chk("hold_idle", {31'd0, done_o}, 32'd0);

        // Reset asserted in the middle of a conversion.
        ynguyen_i   = 4'd7;
        ythapphan_i = 16'hABCD;
        start_i     = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("abort_data", data_o, 32'd0);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni    = 1'b1;
        last_data = 32'd0;
        bad       = 1'b0;
        repeat (25) begin
            @(posedge clk_i); #1;
            if (done_o || data_o != 32'd0 || busy_o) bad = 1'b1;
        end
        chk("post_rst_quiet", {31'd0, bad}, 32'd0);
        conv(4'd7, 16'hABCD, 1'b0, res);

        for (int t = 0; t < 30; t++) begin
            logic [3:0]  rn;
            logic [15:0] rf;
            rn = 4'($urandom_range(0, 15));
            rf = 16'($urandom);
            if (t % 5 == 0) rf = rf & 16'($urandom);
            conv(rn, rf, (t % 7 == 3), res);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/exp_base2_16bit.md
EXP_BASE2_16BIT -- requirements
Module: exp_base2_16bit

Interface
REQ-001 SHALL have parameter FRAC_W, default 16, number of fractional exponent bits processed (one per iteration).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_i  input  1  request; sampled on a rising edge while ready.
REQ-005 SHALL have port ynguyen_i  input  4  integer part n of exponent, 0..15.
REQ-006 SHALL have port ythapphan_i  input  16  fractional part f; bit 15 weighs 2^-1 and bit 0 weighs 2^-16.
REQ-007 SHALL have port busy_o  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done_o  output  1  one-cycle pulse marking data_o newly valid.
REQ-009 SHALL have port data_o  output  32  result 2^(n+f) in unsigned Q16.16.

Function
REQ-010 SHALL implement FSM states IDLE, ITER, SHIFT, DONE; ready means state is IDLE or DONE.
REQ-011 SHALL, on start_i while ready, register ynguyen_i and ythapphan_i, set acc (Q1.15, 16 bit) to 0x8000 and k to 0, and go to ITER.
REQ-012 SHALL, in ITER, examine fraction bit (15-k) on each cycle.
REQ-013 SHALL, in ITER with that bit set, compute acc <= (acc*C[k])>>15 with truncation; with the bit clear, acc SHALL hold.
REQ-014 SHALL, in ITER, increment k each cycle and leave for SHIFT after k=15.
REQ-015 SHALL define C[k] = round(2^(2^-(k+1))*2^15): C[0]=46341, C[1]=38968, C[2]=35734, C[3]=34219; C[15]=32768.
REQ-016 SHALL, in SHIFT, load data_o <= ({15'b0,acc,1'b0}) << n.
REQ-017 SHALL keep the SHIFT result within 32 bits with no overflow, since acc<2^16 and n<=15.
REQ-018 SHALL assert done_o for exactly the DONE cycle; DONE SHALL move to IDLE, or to ITER if start_i is high.
REQ-019 SHALL give fixed latency: done_o high in the 18th cycle after the edge that sampled start_i, independent of data.
REQ-020 SHALL hold busy_o high in ITER and SHIFT, and low in IDLE and DONE.
REQ-021 SHALL ignore start_i while busy_o is high, leaving the registered operands and acc unchanged.
REQ-022 SHALL hold data_o from one SHIFT until the next SHIFT.
REQ-023 SHALL produce exactly 2^n (data_o = 0x10000<<n) when f=0.

Reset
REQ-024 SHALL, while rst_ni is low, asynchronously force state IDLE, acc 0x8000, k 0, registered operands 0, data_o 0, done_o 0 and busy_o 0.
REQ-025 SHALL abort a conversion interrupted by reset, with no done_o pulse; the first start_i after release SHALL begin a fresh conversion.

Structure
REQ-026 SHALL place the state enum, FRAC_W default and the C[] constant table (as a function or localparam array) in shared package exp_base2_pkg.
REQ-027 SHALL use one natural sub-module, exp2_mul_q15: a combinational 16x16 multiply whose output is the product with >>15 truncation; all other logic SHALL be inline.

Verification
REQ-028 SHALL cover: reset, then n=3, f=0x0000 -> done_o at cycle 18 with data_o=0x00080000.
REQ-029 SHALL cover: n=0, f=0x8000 -> data_o=0x00016A0A (2^0.5).
REQ-030 SHALL cover: n=0, f=0xC000 -> data_o=0x0001AE8A (2^0.75).
REQ-031 SHALL cover: n=15, f=0x0000 -> data_o=0x80000000; n=0, f=0x0000 -> data_o=0x00010000.
REQ-032 SHALL cover: start_i pulsed at cycles 5 and 10 of a conversion with different operands -> both ignored, result matches the first operands; start_i held high in DONE -> next done_o exactly 18 cycles later.
REQ-033 SHALL cover: rst_ni low at cycle 9 of a conversion -> outputs 0 immediately, no done_o pulse, data_o=0 until the next completed conversion.
